llc_mem_bridge: RTL and testbench
=================================

LLC_MEM_BRIDGE -- requirements
Module: llc_mem_bridge

Interface
REQ-001 SHALL have parameter WORDS_PER_LINE, default 4, giving the words per cache line; it is a power of two and at least 2.
REQ-002 SHALL have parameter WORD_BITS, default 64, giving the width of one memory beat; it is a power of two and at least 8.
REQ-003 SHALL have parameter LINE_ADDR_BITS, default 26, giving the line-address width.
REQ-004 Derived values: LINE_BITS = WORDS_PER_LINE*WORD_BITS; OFF_BITS = log2(LINE_BITS/8); BYTE_ADDR_BITS = LINE_ADDR_BITS+OFF_BITS.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  in  1  clock; all state updates on its rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 llc_mem_req_valid  in  1  the LLC offers a memory request.
REQ-009 llc_mem_req_ready  out  1  the bridge accepts that request.
REQ-010 llc_mem_req_hwrite  in  1  1 = writeback, 0 = line fill.
REQ-011 llc_mem_req_addr  in  LINE_ADDR_BITS  line address.
REQ-012 llc_mem_req_line  in  LINE_BITS  writeback data; word i is bits [i*WORD_BITS +: WORD_BITS].
REQ-013 llc_mem_rsp_valid  out  1  an assembled fill line is available.
REQ-014 llc_mem_rsp_ready  in  1  the LLC accepts the fill line.
REQ-015 llc_mem_rsp_line  out  LINE_BITS  assembled fill line, in the same word order as REQ-012.
REQ-016 mem_req_valid  out  1  a beat request is offered to the memory.
REQ-017 mem_req_ready  in  1  the memory accepts the beat.
REQ-018 mem_req_we  out  1  1 = beat write, 0 = beat read.
REQ-019 mem_req_addr  out  BYTE_ADDR_BITS  byte address of the beat.
REQ-020 mem_req_wdata  out  WORD_BITS  write data for the beat.
REQ-021 mem_rsp_valid  in  1  the memory returns a read beat.
REQ-022 mem_rsp_ready  out  1  the bridge accepts the read beat.
REQ-023 mem_rsp_rdata  in  WORD_BITS  read data; beats return in request order.

Function
REQ-024 SHALL implement the FSM states IDLE, WRITE, READ and RESP.
REQ-025 IDLE: llc_mem_req_ready=1 and nothing else is asserted; a handshake latches hwrite, addr and line, clears both beat counters, and moves to WRITE if hwrite=1, else READ.
REQ-026 Every handshake in this block means valid and ready are both high at a rising clock edge.
REQ-027 No combinational path from llc_mem_req_valid to any output, and no combinational path from mem_req_ready to any output.
REQ-028 Beat address = {latched addr, beat index (log2(WORDS_PER_LINE) bits), zeros to fill OFF_BITS}, i.e. line base + beat*WORD_BITS/8.
REQ-029 WRITE: mem_req_valid=1, mem_req_we=1, mem_req_wdata = latched word[req_cnt].
REQ-030 WRITE: req_cnt increments on each handshake; the handshake with req_cnt=WORDS_PER_LINE-1 returns to IDLE.
REQ-031 Writebacks produce no LLC response.
REQ-032 READ: mem_req_valid=1 and mem_req_we=0 while req_cnt<WORDS_PER_LINE; mem_rsp_ready=1 throughout.
REQ-033 READ: requests and responses proceed independently; each accepted response writes mem_rsp_rdata into word[rsp_cnt] of the assembly register and increments rsp_cnt.
REQ-034 READ: a request handshake and a response handshake in the same cycle both take effect.
REQ-035 READ -> RESP on the handshake of the response with rsp_cnt=WORDS_PER_LINE-1; a response arriving after its request is accepted in the same cycle or later.
REQ-036 A response arriving in IDLE, WRITE or RESP is not accepted (mem_rsp_ready=0).
REQ-037 RESP: llc_mem_rsp_valid=1 with llc_mem_rsp_line stable until the handshake, then IDLE.
REQ-038 A back-to-back request is accepted no earlier than the cycle after returning to IDLE.
REQ-039 Minimum latency: a write occupies WORDS_PER_LINE cycles; a fill is valid WORDS_PER_LINE+1 cycles after acceptance with zero-wait memory.
REQ-040 Counters are log2(WORDS_PER_LINE)+1 bits wide and never wrap within a transaction.

Reset
REQ-041 While rst=1 at an edge: state=IDLE, counters=0, latched request and assembly registers=0.
REQ-042 After reset, outputs are llc_mem_req_ready=1 and every other valid/ready/we output =0; in-flight beats are dropped.
REQ-043 Reset mid-transaction aborts it; the bench restarts the memory model.

Verification
REQ-044 Write, addr=0x000010, line words 0..3=A0..A3, ready=1: beats at 0x200, 0x208, 0x210, 0x218 carry A0..A3, then IDLE after 4 cycles.
REQ-045 Read, addr=0x000001, memory returns D0..D3 with zero wait: rsp_line = {D3,D2,D1,D0} valid on cycle 5; held while llc_mem_rsp_ready=0 for 3 cycles.
REQ-046 Random mem_req_ready/mem_rsp_valid stalls (50%), 100 mixed transactions: lines match the reference model and no beat is duplicated or dropped.
REQ-047 Simultaneous request and response handshake in every READ cycle: 4 beats complete with the correct order.
REQ-048 rst asserted after 2 write beats: next cycle IDLE, ready=1, mem_req_valid=0; a following read completes correctly.

Source files
------------

// File: rtl/llc_mem_bridge.sv
// Bridges whole-line LLC memory requests onto a single-beat memory port:
// writebacks are split into WORDS_PER_LINE write beats, fills are gathered from read beats.
module llc_mem_bridge #(
  parameter int WORDS_PER_LINE = 4,
  parameter int WORD_BITS      = 64,
  parameter int LINE_ADDR_BITS = 26,
  localparam int LINE_BITS      = WORDS_PER_LINE * WORD_BITS,
  localparam int OFF_BITS       = $clog2(LINE_BITS / 8),
  localparam int BYTE_ADDR_BITS = LINE_ADDR_BITS + OFF_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      llc_mem_req_valid,
  output logic                      llc_mem_req_ready,
  input  logic                      llc_mem_req_hwrite,
  input  logic [LINE_ADDR_BITS-1:0] llc_mem_req_addr,
  input  logic [LINE_BITS-1:0]      llc_mem_req_line,
  output logic                      llc_mem_rsp_valid,
  input  logic                      llc_mem_rsp_ready,
  output logic [LINE_BITS-1:0]      llc_mem_rsp_line,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_we,
  output logic [BYTE_ADDR_BITS-1:0] mem_req_addr,
  output logic [WORD_BITS-1:0]      mem_req_wdata,
  input  logic                      mem_rsp_valid,
  output logic                      mem_rsp_ready,
  input  logic [WORD_BITS-1:0]      mem_rsp_rdata
);

  localparam int IDX_BITS  = $clog2(WORDS_PER_LINE);
  localparam int CNT_BITS  = IDX_BITS + 1;
  localparam int BYTE_BITS = OFF_BITS - IDX_BITS;
  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(WORDS_PER_LINE - 1);
  localparam logic [CNT_BITS-1:0] ONE  = CNT_BITS'(1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t                    state_q;
  logic                      hwrite_q;
  logic [LINE_ADDR_BITS-1:0] addr_q;
  logic [LINE_BITS-1:0]      line_q;
  logic [CNT_BITS-1:0]       req_cnt;
  logic [CNT_BITS-1:0]       rsp_cnt;
  logic [CNT_BITS-1:0]       req_nxt;
  logic                      req_hs;
  logic                      mreq_hs;
  logic                      mrsp_hs;
  logic                      lrsp_hs;

  // Beat byte address: line base plus beat index scaled by the word size.
  function automatic logic [BYTE_ADDR_BITS-1:0] beat_addr(
    input logic [LINE_ADDR_BITS-1:0] line_addr,
    input logic [IDX_BITS-1:0]       beat
  );
    return {line_addr, beat, {BYTE_BITS{1'b0}}};
  endfunction

  function automatic logic [WORD_BITS-1:0] word_of(
    input logic [LINE_BITS-1:0] line,
    input logic [IDX_BITS-1:0]  idx
  );
    return line[int'(idx) * WORD_BITS +: WORD_BITS];
  endfunction

  // Every handshake term is built from registered ready/valid outputs, so no
  // input reaches an output combinationally.
  assign req_hs  = llc_mem_req_valid & llc_mem_req_ready;
  assign mreq_hs = mem_req_valid & mem_req_ready;
  assign mrsp_hs = mem_rsp_valid & mem_rsp_ready;
  assign lrsp_hs = llc_mem_rsp_valid & llc_mem_rsp_ready;
  assign req_nxt = req_cnt + ONE;

  // mem_req_valid is only ever high in WRITE or READ, so this is the WRITE beat flag.
  assign mem_req_we = hwrite_q & mem_req_valid;

  // NOTE: sequential state uses non-blocking assignments only, so every branch
  // below reads the pre-edge values of the registers it updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the wide line/assembly registers are reset too; a reset read of
      // llc_mem_rsp_line must return zeros, not stale data.
      state_q           <= IDLE;
      hwrite_q          <= 1'b0;
      addr_q            <= '0;
      line_q            <= '0;
      req_cnt           <= '0;
      rsp_cnt           <= '0;
      llc_mem_req_ready <= 1'b1;
      llc_mem_rsp_valid <= 1'b0;
      llc_mem_rsp_line  <= '0;
      mem_req_valid     <= 1'b0;
      mem_req_addr      <= '0;
      mem_req_wdata     <= '0;
      mem_rsp_ready     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_hs) begin
            hwrite_q          <= llc_mem_req_hwrite;
            addr_q            <= llc_mem_req_addr;
            line_q            <= llc_mem_req_line;
            req_cnt           <= '0;
            rsp_cnt           <= '0;
            llc_mem_req_ready <= 1'b0;
            mem_req_valid     <= 1'b1;
            mem_req_addr      <= beat_addr(llc_mem_req_addr, '0);
            mem_req_wdata     <= llc_mem_req_hwrite ? word_of(llc_mem_req_line, '0) : '0;
            mem_rsp_ready     <= ~llc_mem_req_hwrite;
            state_q           <= llc_mem_req_hwrite ? WRITE : READ;
          end
        end

        WRITE: begin
          if (mreq_hs) begin
            req_cnt <= req_nxt;
            if (req_cnt == LAST) begin
              mem_req_valid     <= 1'b0;
              llc_mem_req_ready <= 1'b1;
              state_q           <= IDLE;
            end else begin
              mem_req_addr  <= beat_addr(addr_q, req_nxt[IDX_BITS-1:0]);
              mem_req_wdata <= word_of(line_q, req_nxt[IDX_BITS-1:0]);
            end
          end
        end

        READ: begin
          // Request issue and response collection advance independently.
          if (mreq_hs) begin
            req_cnt <= req_nxt;
            if (req_cnt == LAST) begin
              mem_req_valid <= 1'b0;
            end else begin
              mem_req_addr <= beat_addr(addr_q, req_nxt[IDX_BITS-1:0]);
            end
          end
          if (mrsp_hs) begin
            llc_mem_rsp_line[int'(rsp_cnt[IDX_BITS-1:0]) * WORD_BITS +: WORD_BITS] <= mem_rsp_rdata;
            rsp_cnt <= rsp_cnt + ONE;
            if (rsp_cnt == LAST) begin
              mem_req_valid     <= 1'b0;
              mem_rsp_ready     <= 1'b0;
              llc_mem_rsp_valid <= 1'b1;
              state_q           <= RESP;
            end
          end
        end

        RESP: begin
          if (lrsp_hs) begin
            llc_mem_rsp_valid <= 1'b0;
            llc_mem_req_ready <= 1'b1;
            state_q           <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_llc_mem_bridge.sv
// Self-checking bench for llc_mem_bridge: beat scoreboard, memory model with
// optional random stalls, and a reference line store for expected fills.
module tb_llc_mem_bridge;

  localparam int W    = 4;
  localparam int WB   = 64;
  localparam int LA   = 26;
  localparam int LINE = W * WB;
  localparam int OFF  = 5;
  localparam int BA   = LA + OFF;

  typedef struct {
    logic          we;
    logic [BA-1:0] addr;
    logic [WB-1:0] data;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            llc_mem_req_valid = 1'b0;
  logic            llc_mem_req_ready;
  logic            llc_mem_req_hwrite = 1'b0;
  logic [LA-1:0]   llc_mem_req_addr = '0;
  logic [LINE-1:0] llc_mem_req_line = '0;
  logic            llc_mem_rsp_valid;
  logic            llc_mem_rsp_ready = 1'b0;
  logic [LINE-1:0] llc_mem_rsp_line;
  logic            mem_req_valid;
  logic            mem_req_ready = 1'b0;
  logic            mem_req_we;
  logic [BA-1:0]   mem_req_addr;
  logic [WB-1:0]   mem_req_wdata;
  logic            mem_rsp_valid = 1'b0;
  logic            mem_rsp_ready;
  logic [WB-1:0]   mem_rsp_rdata = '0;

  int tests = 0;
  int fails = 0;
  int wr_beats = 0;
  int overlap_cnt = 0;
  logic stall_en = 1'b0;

  beat_t           exp_beats[$];
  logic [WB-1:0]   rsp_q[$];
  logic [LINE-1:0] fill_q[$];
  logic [WB-1:0]   mem_model[logic [BA-1:0]];
  logic [WB-1:0]   ref_mem[logic [BA-1:0]];

  llc_mem_bridge dut (
    .clk                (clk),
    .rst                (rst),
    .llc_mem_req_valid  (llc_mem_req_valid),
    .llc_mem_req_ready  (llc_mem_req_ready),
    .llc_mem_req_hwrite (llc_mem_req_hwrite),
    .llc_mem_req_addr   (llc_mem_req_addr),
    .llc_mem_req_line   (llc_mem_req_line),
    .llc_mem_rsp_valid  (llc_mem_rsp_valid),
    .llc_mem_rsp_ready  (llc_mem_rsp_ready),
    .llc_mem_rsp_line   (llc_mem_rsp_line),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_req_we         (mem_req_we),
    .mem_req_addr       (mem_req_addr),
    .mem_req_wdata      (mem_req_wdata),
    .mem_rsp_valid      (mem_rsp_valid),
    .mem_rsp_ready      (mem_rsp_ready),
    .mem_rsp_rdata      (mem_rsp_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LINE-1:0] obs, input logic [LINE-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Contents of never-written memory: recognisable and address-dependent.
  function automatic logic [WB-1:0] init_word(input logic [BA-1:0] a);
    return {32'hD00D_F00D, 1'b0, a};
  endfunction

  function automatic logic [WB-1:0] mem_read(input logic [BA-1:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return init_word(a);
  endfunction

  function automatic logic [WB-1:0] ref_read(input logic [BA-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  // Memory model: acts #1 after each falling edge; a read beat may be answered
  // in the cycle its request is accepted (zero-wait when stalls are off).
  beat_t mb;
  logic  req_now;
  always @(negedge clk) begin
    #1;
    if (rst) begin
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = '0;
      rsp_q.delete();
    end else begin
      req_now = 1'b0;
      mem_req_ready = !stall_en || ($urandom_range(0, 1) == 1);
      if (mem_req_valid && mem_req_ready) begin
        req_now = 1'b1;
        check("beat_expected", LINE'(exp_beats.size() != 0), LINE'(1));
        if (exp_beats.size() != 0) begin
          mb = exp_beats.pop_front();
          check("beat_we", LINE'(mem_req_we), LINE'(mb.we));
          check("beat_addr", LINE'(mem_req_addr), LINE'(mb.addr));
          if (mb.we) begin
            check("beat_wdata", LINE'(mem_req_wdata), LINE'(mb.data));
            mem_model[mem_req_addr] = mem_req_wdata;
            wr_beats++;
          end else begin
            rsp_q.push_back(mem_read(mem_req_addr));
          end
        end
      end
      if (rsp_q.size() != 0 && (!stall_en || $urandom_range(0, 1) == 1)) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = rsp_q[0];
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
      end
      if (mem_rsp_valid && mem_rsp_ready) begin
        rsp_q.delete(0);
        if (req_now) overlap_cnt++;
      end
    end
  end

  // Offer one LLC request at the current falling edge and queue its expectations.
  task automatic issue(input logic hw, input logic [LA-1:0] a, input logic [LINE-1:0] ln);
    int              n;
    beat_t           b;
    logic [LINE-1:0] exp_line;
    n = 0;
    exp_line = '0;
    llc_mem_req_valid  = 1'b1;
    llc_mem_req_hwrite = hw;
    llc_mem_req_addr   = a;
    llc_mem_req_line   = ln;
    while (!llc_mem_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_accept", LINE'(llc_mem_req_ready), LINE'(1));
    for (int i = 0; i < W; i++) begin
      b.we   = hw;
      b.addr = (BA'(a) << OFF) + BA'(i * 8);
      b.data = hw ? ln[i*WB +: WB] : '0;
      exp_beats.push_back(b);
      if (hw) ref_mem[b.addr] = b.data;
      else exp_line[i*WB +: WB] = ref_read(b.addr);
    end
    if (!hw) fill_q.push_back(exp_line);
    @(negedge clk);
    llc_mem_req_valid = 1'b0;
  endtask

  // Wait for completion; cyc counts falling edges since the accepting edge.
  task automatic wait_done(input logic hw, input int hold, output int cyc);
    logic [LINE-1:0] expl;
    cyc = 1;
    if (hw) begin
      while (!llc_mem_req_ready && cyc < 400) begin
        @(negedge clk);
        cyc++;
      end
      check("wr_done", LINE'(llc_mem_req_ready), LINE'(1));
    end else begin
      while (!llc_mem_rsp_valid && cyc < 400) begin
        @(negedge clk);
        cyc++;
      end
      check("rd_valid", LINE'(llc_mem_rsp_valid), LINE'(1));
      if (llc_mem_rsp_valid && fill_q.size() != 0) begin
        expl = fill_q.pop_front();
        for (int h = 0; h < hold; h++) begin
          check("rd_hold_line", llc_mem_rsp_line, expl);
          @(negedge clk);
          check("rd_hold_valid", LINE'(llc_mem_rsp_valid), LINE'(1));
        end
        check("rd_line", llc_mem_rsp_line, expl);
        llc_mem_rsp_ready = 1'b1;
        @(negedge clk);
        llc_mem_rsp_ready = 1'b0;
        check("rd_release", LINE'(llc_mem_rsp_valid), LINE'(0));
        check("rd_idle", LINE'(llc_mem_req_ready), LINE'(1));
      end
    end
  endtask

  logic [LINE-1:0] ln;
  logic            hw;
  int              cyc;
  int              wr0;
  int              n;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_req_ready", LINE'(llc_mem_req_ready), LINE'(1));
    check("rst_mem_valid", LINE'(mem_req_valid), LINE'(0));
    check("rst_mem_we", LINE'(mem_req_we), LINE'(0));
    check("rst_rsp_ready", LINE'(mem_rsp_ready), LINE'(0));
    check("rst_llc_valid", LINE'(llc_mem_rsp_valid), LINE'(0));
    check("rst_line", llc_mem_rsp_line, '0);
    rst = 1'b0;
    @(negedge clk);

    // Writeback of A0..A3 to line 0x10: beats 0x200..0x218.
    ln = {64'hA3A3_A3A3_0000_0003, 64'hA2A2_A2A2_0000_0002,
          64'hA1A1_A1A1_0000_0001, 64'hA0A0_A0A0_0000_0000};
    issue(1'b1, 26'h10, ln);
    wait_done(1'b1, 0, cyc);
    check("wr_latency", LINE'(cyc), LINE'(W + 1));

    // Fill of line 0x1 from unwritten memory, held off for three cycles.
    issue(1'b0, 26'h1, '0);
    wait_done(1'b0, 3, cyc);
    check("rd_latency", LINE'(cyc), LINE'(W + 1));

    // Zero-wait fill of the written line: every beat overlaps request and response.
    overlap_cnt = 0;
    issue(1'b0, 26'h10, '0);
    wait_done(1'b0, 0, cyc);
    check("rd_overlap", LINE'(overlap_cnt), LINE'(W));
    check("rd2_latency", LINE'(cyc), LINE'(W + 1));

    // Mixed traffic with random stalls on both memory channels.
    stall_en = 1'b1;
    for (int t = 0; t < 100; t++) begin
      hw = 1'($urandom_range(0, 1));
      for (int i = 0; i < LINE / 32; i++) ln[i*32 +: 32] = $urandom();
      issue(hw, LA'($urandom_range(0, 7)), ln);
      wait_done(hw, $urandom_range(0, 2), cyc);
    end
    stall_en = 1'b0;
    @(negedge clk);
    check("queues_drained", LINE'(exp_beats.size() + rsp_q.size() + fill_q.size()), '0);

    // Reset after two write beats of line 0x20, then read it back.
    wr0 = wr_beats;
    ln = {64'hB3B3_0000_0000_0003, 64'hB2B2_0000_0000_0002,
          64'hB1B1_0000_0000_0001, 64'hB0B0_0000_0000_0000};
    issue(1'b1, 26'h20, ln);
    n = 0;
    #2;
    while (wr_beats - wr0 < 2 && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("rst_mid_beats_seen", LINE'(wr_beats - wr0), LINE'(2));
    @(negedge clk);
    rst = 1'b1;
    exp_beats.delete();
    ref_mem.delete((BA'(26'h20) << OFF) + BA'(16));
    ref_mem.delete((BA'(26'h20) << OFF) + BA'(24));
    @(negedge clk);
    check("rst_mid_ready", LINE'(llc_mem_req_ready), LINE'(1));
    check("rst_mid_valid", LINE'(mem_req_valid), LINE'(0));
    check("rst_mid_beats", LINE'(wr_beats - wr0), LINE'(2));
    rst = 1'b0;
    @(negedge clk);
    issue(1'b0, 26'h20, '0);
    wait_done(1'b0, 1, cyc);
    check("rst_rd_latency", LINE'(cyc), LINE'(W + 1));
    @(negedge clk);
    check("final_drained", LINE'(exp_beats.size() + rsp_q.size() + fill_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
